// File: rtl/arcade_input_conditioner.sv
// Player-input conditioner: 2-flop sync and tick-based debounce for every bit,
// plus rate-limited, queued coin pulses on the low COINS channels.
module arcade_input_conditioner #(
    parameter int NUM_IN         = 16,
    parameter int COINS          = 2,
    parameter int TICK_DIV       = 18000,
    parameter int DB_TICKS       = 5,
    parameter int COIN_ON_TICKS  = 100,
    parameter int COIN_OFF_TICKS = 100
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NUM_IN-1:0] raw_in,
    input  logic              clear,
    output logic [NUM_IN-1:0] ctrl_out,
    output logic [COINS-1:0]  coin_busy,
    output logic [COINS-1:0]  coin_ovf,
    output logic              tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } coin_state_e;

    logic [TW-1:0]                tick_cnt_q, tick_cnt_d;
    logic [NUM_IN-1:0]            sync1_q, sync1_d;
    logic [NUM_IN-1:0]            sync2_q, sync2_d;
    logic [NUM_IN-1:0]            stable_q, stable_d;
    logic [NUM_IN-1:0][7:0]       dbc_q, dbc_d;
    logic [COINS-1:0][1:0]        pending_q, pending_d;
    logic [COINS-1:0][9:0]        timer_q, timer_d;
    logic [COINS-1:0]             ovf_q, ovf_d;
    logic [COINS-1:0]             coin_rise;
    logic [COINS-1:0]             coin_dec;
    coin_state_e                  state_q [COINS];
    coin_state_e                  state_d [COINS];

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        sync1_d    = raw_in;
        sync2_d    = sync1_q;
    end

    always_comb begin
        stable_d = stable_q;
        dbc_d    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (!tick) begin
                    dbc_d[i] = dbc_q[i];
                end else if (dbc_q[i] + 8'd1 == 8'(DB_TICKS)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + 8'd1;
                end
            end
        end
    end

    // Edge is taken from the debounce next-state so a fresh insert reaches
    // the pending count on the same edge stable rises.
    always_comb begin
        coin_rise = stable_d[COINS-1:0] & ~stable_q[COINS-1:0];
        coin_dec  = '0;
        pending_d = pending_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        for (int c = 0; c < COINS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                S_IDLE: begin
                    if (pending_q[c] != 2'd0) begin
                        state_d[c]  = S_ON;
                        timer_d[c]  = '0;
                        coin_dec[c] = 1'b1;
                    end
                end
                S_ON: begin
                    if (tick) begin
                        if (timer_q[c] + 10'd1 == 10'(COIN_ON_TICKS)) begin
                            state_d[c] = S_OFF;
                            timer_d[c] = '0;
                        end else begin
                            timer_d[c] = timer_q[c] + 10'd1;
                        end
                    end
                end
                S_OFF: begin
                    if (tick) begin
                        if (timer_q[c] + 10'd1 == 10'(COIN_OFF_TICKS)) begin
                            state_d[c] = S_IDLE;
                            timer_d[c] = '0;
                        end else begin
                            timer_d[c] = timer_q[c] + 10'd1;
                        end
                    end
                end
                default: begin
                    state_d[c] = S_IDLE;
                    timer_d[c] = '0;
                end
            endcase

            // A simultaneous insert and launch cancel out, even with a full queue.
            if (coin_rise[c] && !coin_dec[c]) begin
                if (pending_q[c] == 2'd3) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    pending_d[c] = pending_q[c] + 2'd1;
                end
            end else if (!coin_rise[c] && coin_dec[c]) begin
                pending_d[c] = pending_q[c] - 2'd1;
            end

            if (clear) begin
                state_d[c]   = S_IDLE;
                timer_d[c]   = '0;
                pending_d[c] = '0;
                ovf_d[c]     = 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_out  = stable_q;
        coin_busy = '0;
        for (int c = 0; c < COINS; c++) begin
            ctrl_out[c]  = (state_q[c] == S_ON);
            coin_busy[c] = (state_q[c] != S_IDLE) || (pending_q[c] != 2'd0);
        end
        coin_ovf = ovf_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            dbc_q      <= '0;
            pending_q  <= '0;
            timer_q    <= '0;
            ovf_q      <= '0;
            for (int c = 0; c < COINS; c++) begin
                state_q[c] <= S_IDLE;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            dbc_q      <= dbc_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            ovf_q      <= ovf_d;
            for (int c = 0; c < COINS; c++) begin
                state_q[c] <= state_d[c];
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench: instance A uses a 4-cycle tick for debounce/pulse timing,
// instance B ticks every cycle with a long ON time to exercise the coin queue.
module tb_arcade_input_conditioner;

    logic        clk;
    logic        reset_n;
    logic [15:0] raw_a, raw_b;
    logic        clear_a, clear_b;
    logic [15:0] ctrl_a, ctrl_b;
    logic [1:0]  busy_a, busy_b;
    logic [1:0]  ovf_a, ovf_b;
    logic        tick_a, tick_b;

    int total;
    int bad;
    int cyc;

    arcade_input_conditioner #(
        .NUM_IN(16), .COINS(2), .TICK_DIV(4), .DB_TICKS(3),
        .COIN_ON_TICKS(2), .COIN_OFF_TICKS(2)
    ) dut (
        .clk_sys(clk), .reset_n(reset_n), .raw_in(raw_a), .clear(clear_a),
        .ctrl_out(ctrl_a), .coin_busy(busy_a), .coin_ovf(ovf_a), .tick(tick_a)
    );

    arcade_input_conditioner #(
        .NUM_IN(16), .COINS(2), .TICK_DIV(1), .DB_TICKS(1),
        .COIN_ON_TICKS(10), .COIN_OFF_TICKS(2)
    ) dut_q (
        .clk_sys(clk), .reset_n(reset_n), .raw_in(raw_b), .clear(clear_b),
        .ctrl_out(ctrl_b), .coin_busy(busy_b), .coin_ovf(ovf_b), .tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    // Release lands on a falling edge, so the next rising edge is cycle 1.
    task automatic do_reset(input logic [15:0] va);
        reset_n = 1'b0;
        raw_a   = va;
        raw_b   = '0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        do_reset(16'hFFFF);
        total++;
        if (ctrl_a !== 16'h0 || busy_a !== 2'b00 || ovf_a !== 2'b00 || tick_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got ctrl=%h busy=%b ovf=%b tick=%b want all zero",
                     ctrl_a, busy_a, ovf_a, tick_a);
        end
        while (cyc < 20) begin
            step();
            if (cyc == 2 || cyc == 3 || cyc == 4) begin
                total++;
                if (tick_a !== (cyc == 3)) begin
                    bad++;
                    $display("FAIL tick_phase cyc=%0d got=%b want=%b", cyc, tick_a, (cyc == 3));
                end
            end
            if (cyc == 11) begin
                total++;
                if (ctrl_a !== 16'h0) begin
                    bad++;
                    $display("FAIL reset_db_early got=%h want=0000", ctrl_a);
                end
            end
            if (cyc == 12) begin
                total++;
                if (ctrl_a !== 16'hFFFC || busy_a !== 2'b11) begin
                    bad++;
                    $display("FAIL reset_db_accept got ctrl=%h busy=%b want ctrl=fffc busy=11",
                             ctrl_a, busy_a);
                end
            end
            if (cyc == 13) begin
                total++;
                if (ctrl_a !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL reset_coin_rise got=%h want=ffff", ctrl_a);
                end
            end
            if (cyc == 15) begin
                reset_n = 1'b0;
                #1;
                total++;
                if (ctrl_a !== 16'h0 || busy_a !== 2'b00) begin
                    bad++;
                    $display("FAIL async_reset_midpulse got ctrl=%h busy=%b want 0000/00",
                             ctrl_a, busy_a);
                end
                cyc = 20;
            end
        end
    endtask

    task automatic test_coin_pair_pulse();
        do_reset(16'hFFFF);
        while (cyc < 40) begin
            step();
            if (cyc == 19 || cyc == 20) begin
                total++;
                if (ctrl_a[1:0] !== ((cyc == 19) ? 2'b11 : 2'b00)) begin
                    bad++;
                    $display("FAIL pair_pulse_end cyc=%0d got=%b", cyc, ctrl_a[1:0]);
                end
            end
            if (cyc == 27 || cyc == 28) begin
                total++;
                if (busy_a !== ((cyc == 27) ? 2'b11 : 2'b00)) begin
                    bad++;
                    $display("FAIL pair_busy_end cyc=%0d got=%b", cyc, busy_a);
                end
            end
        end
        total++;
        if (ctrl_a[1:0] !== 2'b00 || ctrl_a[15:2] !== 14'h3FFF) begin
            bad++;
            $display("FAIL pair_held_steady got=%h want=fffc", ctrl_a);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        do_reset(16'h0000);
        while (cyc < 36) begin
            step();
            if (cyc == 4)  raw_a[4] = 1'b1;
            if (cyc == 12) raw_a[4] = 1'b0;
            if (cyc == 24) raw_a[4] = 1'b1;
            if (cyc <= 35 && ctrl_a[4] !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_filtered got=1 want=0");
        end
        total++;
        if (ctrl_a[4] !== 1'b1 || ctrl_a[3:0] !== 4'h0) begin
            bad++;
            $display("FAIL glitch_accept got=%h want bit4 only", ctrl_a);
        end
    endtask

    task automatic test_single_coin();
        int   rises;
        int   highs;
        int   tick_hi;
        logic prev;
        rises = 0; highs = 0; tick_hi = 0; prev = 1'b0;
        do_reset(16'h0000);
        while (cyc < 90) begin
            step();
            if (cyc == 4)  raw_a[0] = 1'b1;
            if (cyc == 84) raw_a[0] = 1'b0;
            if (ctrl_a[0] && !prev) rises++;
            if (ctrl_a[0]) begin
                highs++;
                if (tick_a) tick_hi++;
            end
            prev = ctrl_a[0];
            if (cyc == 16) begin
                total++;
                if (ctrl_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL coin_queued got ctrl=%b busy=%b want 0/1", ctrl_a[0], busy_a[0]);
                end
            end
            if (cyc == 17) begin
                total++;
                if (ctrl_a[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL coin_latency got=%b want=1", ctrl_a[0]);
                end
            end
            if (cyc == 31 || cyc == 32) begin
                total++;
                if (busy_a[0] !== (cyc == 31)) begin
                    bad++;
                    $display("FAIL coin_busy_gap cyc=%0d got=%b", cyc, busy_a[0]);
                end
            end
        end
        // The pulse starts one cycle into a tick period, so it spans two tick
        // strobes but one cycle less than two full periods.
        total++;
        if (rises !== 1 || highs !== 7 || tick_hi !== 2) begin
            bad++;
            $display("FAIL coin_single got rises=%0d highs=%0d ticks=%0d want 1/7/2",
                     rises, highs, tick_hi);
        end
        total++;
        if (ovf_a !== 2'b00 || busy_a !== 2'b00) begin
            bad++;
            $display("FAIL coin_single_idle got ovf=%b busy=%b want 00/00", ovf_a, busy_a);
        end
    endtask

    task automatic run_presses(input int npress, input int extra_at, input int ncyc,
                               output int rises, output int highs);
        logic prev;
        rises = 0; highs = 0; prev = 1'b0;
        do_reset(16'h0000);
        while (cyc < ncyc) begin
            step();
            raw_b[0] = ((cyc % 2 == 1) && (cyc <= 2 * npress - 1)) || (cyc == extra_at);
            if (ctrl_b[0] && !prev) rises++;
            if (ctrl_b[0]) highs++;
            prev = ctrl_b[0];
            if (cyc == 5 && ctrl_b[0] !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL queue_first_latency got=0 want=1");
            end
            if (cyc == 14 || cyc == 15 || cyc == 17 || cyc == 18) begin
                total++;
                if (ctrl_b[0] !== (cyc == 14 || cyc == 18)) begin
                    bad++;
                    $display("FAIL queue_gap cyc=%0d got=%b", cyc, ctrl_b[0]);
                end
            end
            if (cyc == 11 || cyc == 12) begin
                total++;
                if (ovf_b[0] !== (npress >= 5 && cyc == 12)) begin
                    bad++;
                    $display("FAIL queue_ovf cyc=%0d got=%b want=%b", cyc, ovf_b[0],
                             (npress >= 5 && cyc == 12));
                end
            end
        end
    endtask

    task automatic test_queue();
        int rises;
        int highs;
        run_presses(4, -1, 70, rises, highs);
        total++;
        if (rises !== 4 || highs !== 40 || ovf_b !== 2'b00 || busy_b !== 2'b00) begin
            bad++;
            $display("FAIL queue_four got rises=%0d highs=%0d ovf=%b busy=%b want 4/40/00/00",
                     rises, highs, ovf_b, busy_b);
        end
        run_presses(5, -1, 70, rises, highs);
        total++;
        if (rises !== 4 || ovf_b !== 2'b01) begin
            bad++;
            $display("FAIL queue_five got rises=%0d ovf=%b want 4/01", rises, ovf_b);
        end
        clear_b = 1'b1;
        step();
        clear_b = 1'b0;
        total++;
        if (ovf_b !== 2'b00) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=00", ovf_b);
        end
    endtask

    task automatic test_simultaneous();
        int rises;
        int highs;
        run_presses(4, 15, 100, rises, highs);
        total++;
        if (rises !== 5 || highs !== 50 || ovf_b !== 2'b00 || busy_b !== 2'b00) begin
            bad++;
            $display("FAIL simul_net_zero got rises=%0d highs=%0d ovf=%b busy=%b want 5/50/00/00",
                     rises, highs, ovf_b, busy_b);
        end
    endtask

    task automatic test_clear_midpulse();
        int   rises;
        logic prev;
        rises = 0; prev = 1'b0;
        do_reset(16'h0000);
        while (cyc < 60) begin
            step();
            raw_b[0] = (cyc == 1) || (cyc == 3) || (cyc >= 5);
            if (cyc == 9) begin
                total++;
                if (ctrl_b[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL clear_pre got ctrl=%b busy=%b want 1/1", ctrl_b[0], busy_b[0]);
                end
                clear_b = 1'b1;
            end
            if (cyc == 10) begin
                clear_b = 1'b0;
                total++;
                if (ctrl_b[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL clear_post got ctrl=%b busy=%b want 0/0", ctrl_b[0], busy_b[0]);
                end
            end
            if (cyc > 10 && ctrl_b[0] && !prev) rises++;
            prev = ctrl_b[0];
        end
        total++;
        if (rises !== 0 || busy_b[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_no_retrigger got rises=%0d busy=%b want 0/0", rises, busy_b[0]);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        reset_n = 1'b0;
        raw_a   = '0;
        raw_b   = '0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        test_reset();
        test_coin_pair_pulse();
        test_glitch();
        test_single_coin();
        test_queue();
        test_simultaneous();
        test_clear_midpulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
